// File: rtl/tl_pkg.sv
// Shared constants for the two-road traffic light sequencer: light codes and
// the phase state encodings (S_WALK only reachable with TL_PED_PHASE_EN).
package tl_pkg;

   localparam logic [1:0] GREEN  = 2'b00;
   localparam logic [1:0] YELLOW = 2'b01;
   localparam logic [1:0] RED    = 2'b10;

   localparam logic [2:0] S_AG   = 3'b000;
   localparam logic [2:0] S_AY   = 3'b001;
   localparam logic [2:0] S_BG   = 3'b010;
   localparam logic [2:0] S_BY   = 3'b011;
   localparam logic [2:0] S_WALK = 3'b100;

endpackage

// File: rtl/tl_light_decode.sv
// Pure combinational decode of the phase state into the light codes,
// the walk lamp and the base phase code.
module tl_light_decode (
   input  logic [2:0] state,
   input  logic       next_dir,
   output logic [1:0] La,
   output logic [1:0] Lb,
   output logic       walk,
   output logic [1:0] q
);
   import tl_pkg::*;

   always_comb begin
      La   = RED;
      Lb   = RED;
      walk = 1'b0;
      q    = state[1:0];
      case (state)
         S_AG:    La = GREEN;
         S_AY:    La = YELLOW;
         S_BG:    Lb = GREEN;
         S_BY:    Lb = YELLOW;
         // During walk, q keeps the code of the yellow that led into it.
         S_WALK: begin
            walk = 1'b1;
            q    = next_dir ? 2'b01 : 2'b11;
         end
         default: q = 2'b00;
      endcase
   end

endmodule

// File: rtl/tl_phase_sequencer.sv
// Timed phase sequencer for a two-road traffic light. Defining TL_PED_PHASE_EN
// adds the pedestrian all-red walk phase with its request/acknowledge handshake.
module tl_phase_sequencer #(
   parameter int GREEN_MIN     = 4,
   parameter int GREEN_MAX     = 8,
   parameter int YELLOW_CYCLES = 2,
   parameter int WALK_CYCLES   = 3,
   parameter int CNT_W         = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       Ta,
   input  logic       Tb,
   input  logic       ped_req,
   output logic [1:0] La,
   output logic [1:0] Lb,
   output logic       walk,
   output logic       ped_ack,
   output logic [1:0] q
);
   import tl_pkg::*;

   localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_CYCLES - 1);

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [CNT_W-1:0] timer;
   logic             a_done;
   logic             b_done;
   logic             yel_done;
   logic             next_dir;
   logic             walk_dec;

   assign a_done   = (timer == MAX_LAST) || ((timer >= MIN_LAST) && !Ta);
   assign b_done   = (timer == MAX_LAST) || ((timer >= MIN_LAST) && !Tb);
   assign yel_done = (timer == YEL_LAST);

`ifdef TL_PED_PHASE_EN
   localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_CYCLES - 1);

   logic ped_pending;
   logic walk_done;

   assign walk_done = (timer == WALK_LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         S_AG:    if (a_done) state_nxt = S_AY;
         S_AY:    if (yel_done) state_nxt = ped_pending ? S_WALK : S_BG;
         S_BG:    if (b_done) state_nxt = S_BY;
         S_BY:    if (yel_done) state_nxt = ped_pending ? S_WALK : S_AG;
         S_WALK:  if (walk_done) state_nxt = next_dir ? S_BG : S_AG;
         default: state_nxt = S_AG;
      endcase
   end

   // Entering walk consumes the request; requests seen during walk are dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ped_pending <= 1'b0;
         next_dir    <= 1'b1;
      end else if (state != S_WALK && state_nxt == S_WALK) begin
         ped_pending <= 1'b0;
         next_dir    <= (state == S_AY);
      end else if (ped_req && state != S_WALK) begin
         ped_pending <= 1'b1;
      end
   end

   assign ped_ack = (state == S_WALK) && (timer == '0);
   assign walk    = walk_dec;
`else
   logic unused_sink;

   always_comb begin
      state_nxt = state;
      case (state)
         S_AG:    if (a_done) state_nxt = S_AY;
         S_AY:    if (yel_done) state_nxt = S_BG;
         S_BG:    if (b_done) state_nxt = S_BY;
         S_BY:    if (yel_done) state_nxt = S_AG;
         default: state_nxt = S_AG;
      endcase
   end

   assign next_dir    = 1'b1;
   assign ped_ack     = 1'b0;
   assign walk        = 1'b0;
   assign unused_sink = ped_req ^ walk_dec;
`endif

   // Phase register and dwell timer; the timer restarts on every phase change.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_AG;
         timer <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state) begin
            timer <= '0;
         end else if (timer != '1) begin
            timer <= timer + 1'b1;
         end
      end
   end

   tl_light_decode u_decode (
      .state    (state),
      .next_dir (next_dir),
      .La       (La),
      .Lb       (Lb),
      .walk     (walk_dec),
      .q        (q)
   );

endmodule

// File: doc/tl_phase_sequencer.md
# tl_phase_sequencer

Timed phase sequencer for the two-road traffic light controller. It owns the phase state register, a per-phase cycle timer, and an optional pedestrian all-red walk phase. It decides when road A and road B change lights from the car sensors and minimum/maximum green times. It drives the La/Lb light codes consumed by the signal-head drivers, plus the walk lamp and the pedestrian handshake.

## Interface
- GREEN_MIN, 4: minimum cycles a road holds green (≥1)
- GREEN_MAX, 8: maximum cycles a road holds green (GREEN_MIN ≤ GREEN_MAX ≤ 2^CNT_W)
- YELLOW_CYCLES, 2: exact yellow duration (≥1)
- WALK_CYCLES, 3: exact all-red walk duration (≥1)
- CNT_W, 4: phase timer width
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- Ta  input  1  car present on road A
- Tb  input  1  car present on road B
- ped_req  input  1  pedestrian request, level, held until ped_ack
- La  output  2  road A light: green 2'b00, yellow 2'b01, red 2'b10
- Lb  output  2  road B light, same encoding
- walk  output  1  walk lamp
- ped_ack  output  1  one-cycle acknowledge of ped_req
- q  output  2  current base phase code (for status/debug)

## Operation
- States:
  - S_AG: A green / B red, q=00
  - S_AY: A yellow / B red, q=01
  - S_BG: B green / A red, q=10
  - S_BY: B yellow / A red, q=11
  - S_WALK: both red, walk=1, q holds the preceding yellow code
- Timer: cleared on every state change; increments each cycle in the same state; saturates at 2^CNT_W−1.
- S_AG exits to S_AY when timer==GREEN_MAX−1, or when timer≥GREEN_MIN−1 and Ta==0.
- S_BG mirrors S_AG using Tb, exiting to S_BY.
- S_AY exits after YELLOW_CYCLES:
  - to S_WALK if ped_pending=1 (macro enabled)
  - otherwise to S_BG
- S_BY exits the same way, going to S_WALK or S_AG.
- S_WALK lasts WALK_CYCLES, then enters the green of the road that did not just go yellow. A 1-bit next_dir register holds this.
- ped_pending:
  - set in any cycle with ped_req=1 and state≠S_WALK
  - cleared on entry to S_WALK
  - ped_req is ignored while in S_WALK
- ped_ack: high only in the first cycle of S_WALK.
- If the requester still holds ped_req after S_WALK ends (protocol violation), a new request latches. This is legal, defined behaviour.
- La/Lb/walk/q are a pure decode of the state register (no extra register stage).

## Timing
- Reset (asynchronous, immediate): state S_AG, timer 0, ped_pending 0, next_dir B.
- Outputs during reset: La=00, Lb=10, walk=0, ped_ack=0, q=00.
- Green duration: GREEN_MIN to GREEN_MAX cycles inclusive. Yellow: exactly YELLOW_CYCLES. Walk: exactly WALK_CYCLES.
- Sensor inputs are sampled at the rising edge. Ta falling in cycle N (with minimum met) puts S_AY in effect at cycle N+1.
- ped_req asserted during the last yellow cycle is latched but misses that transition. It is served at the next yellow→green boundary.
- Simultaneous exit conditions (min met with sensor low, and max reached): single transition, identical result.
- reset_n asserted mid-phase or mid-walk: immediate return to reset values. A pending request is lost; the requester keeps ped_req high and is re-latched after release.

## Configuration
- TL_PED_PHASE_EN defined: S_WALK, ped_pending, ped_ack and walk are implemented as above.
- Macro undefined:
  - no S_WALK state and no pending register
  - ped_req ignored
  - ped_ack and walk tied 0
  - yellow always goes directly to the opposite green

## Structure
- Shared package tl_pkg holds:
  - light codes GREEN/YELLOW/RED
  - the state enumeration with S_AG..S_BY encodings 00..11 (S_WALK 100)
- Sub-module tl_light_decode: state → La, Lb, walk, q (combinational).
- Timer and FSM stay in the top module.

## Test plan
All scenarios use default parameters.
- Reset check: reset_n=0 → La=00, Lb=10, walk=0, ped_ack=0.
- Ta=0, Tb=1 after reset:
  - A green for exactly 4 cycles, then 2 cycles La=01
  - then La=10, Lb=00, lasting 8 cycles while Tb=1
- Ta=1 held: S_AG lasts exactly 8 cycles (GREEN_MAX) before La=01.
- Macro on, ped_req=1 in cycle 2 of S_AG, Ta=0:
  - after yellow, 3 cycles with La=Lb=10 and walk=1
  - ped_ack pulses in the first walk cycle
  - then Lb=00
- reset_n pulsed low during S_BG cycle 3 → La=00, Lb=10 immediately; A green restarts its 4-cycle minimum after release.
- Macro off, ped_req=1 held: sequence identical to the no-request case; walk=0 and ped_ack=0 throughout.
